// File: rtl/riscv_defines.sv
// Shared ALU operator encodings and divider FSM state type.
package riscv_defines;

    localparam int unsigned ALU_OP_WIDTH = 7;

    localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD  = 7'b0011000;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB  = 7'b0011001;
    // Divide family: bit 0 selects signed, bit 1 selects remainder.
    localparam logic [ALU_OP_WIDTH-1:0] ALU_DIVU = 7'b0110000;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_DIV  = 7'b0110001;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_REMU = 7'b0110010;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_REM  = 7'b0110011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    function automatic logic is_div_op(input logic [ALU_OP_WIDTH-1:0] op);
        return (op == ALU_DIVU) || (op == ALU_DIV) || (op == ALU_REMU) || (op == ALU_REM);
    endfunction

endpackage

// File: rtl/riscv_div_step.sv
// One radix-2 restoring division step: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference when it does not underflow.
module riscv_div_step #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH:0]   rem_i,
    input  logic [DATA_WIDTH-1:0] quot_i,
    input  logic [DATA_WIDTH-1:0] divisor_i,
    output logic [DATA_WIDTH:0]   rem_o,
    output logic [DATA_WIDTH-1:0] quot_o
);

    logic [DATA_WIDTH:0] shifted;
    logic [DATA_WIDTH:0] diff;
    logic                q_bit;

    assign shifted = (rem_i << 1) | (DATA_WIDTH+1)'(quot_i[DATA_WIDTH-1]);
    assign diff    = shifted - {1'b0, divisor_i};

    always_comb begin
        q_bit = 1'b0;
        rem_o = shifted;
        if (!diff[DATA_WIDTH]) begin
            q_bit = 1'b1;
            rem_o = diff;
        end
    end

    // Dividend bits leave at the MSB while quotient bits enter at the LSB.
    assign quot_o = {quot_i[DATA_WIDTH-2:0], q_bit};

endmodule

// File: rtl/riscv_div_seq.sv
// Sequential radix-2 divider for DIV/DIVU/REM/REMU with fixed latency,
// divide-by-zero shortcut, flush and a DONE hold until downstream accepts.
module riscv_div_seq
    import riscv_defines::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable_i,
    input  logic [ALU_OP_WIDTH-1:0] operator_i,
    input  logic [DATA_WIDTH-1:0]   op_a_i,
    input  logic [DATA_WIDTH-1:0]   op_b_i,
    input  logic                    flush_i,
    input  logic                    ex_ready_i,
    output logic                    ready_o,
    output logic                    valid_o,
    output logic [DATA_WIDTH-1:0]   result_o
);

    localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    div_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH:0]   rem_q, rem_d;
    logic [DATA_WIDTH-1:0] quot_q, quot_d;
    logic [DATA_WIDTH-1:0] divisor_q, divisor_d;
    logic                  neg_quot_q, neg_quot_d;
    logic                  neg_rem_q, neg_rem_d;
    logic                  sel_rem_q, sel_rem_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  ready_q, ready_d;
    logic                  valid_q, valid_d;

    logic [DATA_WIDTH:0]   step_rem;
    logic [DATA_WIDTH-1:0] step_quot;

    logic                  accept_c;
    logic                  a_neg_c, b_neg_c;
    logic [DATA_WIDTH-1:0] a_mag_c, b_mag_c;
    logic [DATA_WIDTH-1:0] rem_low_c;

    riscv_div_step #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_step (
        .rem_i     (rem_q),
        .quot_i    (quot_q),
        .divisor_i (divisor_q),
        .rem_o     (step_rem),
        .quot_o    (step_quot)
    );

    assign accept_c = enable_i && ready_q && !flush_i && is_div_op(operator_i);

    // Magnitudes are taken unsigned so the most-negative value is representable.
    assign a_neg_c   = operator_i[0] & op_a_i[DATA_WIDTH-1];
    assign b_neg_c   = operator_i[0] & op_b_i[DATA_WIDTH-1];
    assign a_mag_c   = a_neg_c ? (DATA_WIDTH'(0) - op_a_i) : op_a_i;
    assign b_mag_c   = b_neg_c ? (DATA_WIDTH'(0) - op_b_i) : op_b_i;
    assign rem_low_c = rem_q[DATA_WIDTH-1:0];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        divisor_d  = divisor_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        sel_rem_d  = sel_rem_q;
        result_d   = result_q;
        ready_d    = ready_q;
        valid_d    = valid_q;

        unique case (state_q)
            IDLE: begin
                if (accept_c) begin
                    rem_d      = '0;
                    quot_d     = a_mag_c;
                    divisor_d  = b_mag_c;
                    neg_quot_d = a_neg_c ^ b_neg_c;
                    neg_rem_d  = a_neg_c;
                    sel_rem_d  = operator_i[1];
                    ready_d    = 1'b0;
                    if (op_b_i == '0) begin
                        state_d  = DONE;
                        valid_d  = 1'b1;
                        result_d = operator_i[1] ? op_a_i : '1;
                    end else begin
                        state_d = DIV;
                        cnt_d   = CNT_W'(DATA_WIDTH - 1);
                    end
                end
            end
            DIV: begin
                rem_d  = step_rem;
                quot_d = step_quot;
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            FIX: begin
                if (sel_rem_q) begin
                    result_d = neg_rem_q ? (DATA_WIDTH'(0) - rem_low_c) : rem_low_c;
                end else begin
                    result_d = neg_quot_q ? (DATA_WIDTH'(0) - quot_q) : quot_q;
                end
                state_d = DONE;
                valid_d = 1'b1;
            end
            DONE: begin
                if (ex_ready_i) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
                valid_d = 1'b0;
            end
        endcase

        // Flush wins over accept and over the downstream handshake.
        if (flush_i) begin
            state_d = IDLE;
            ready_d = 1'b1;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            divisor_q  <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            sel_rem_q  <= 1'b0;
            result_q   <= '0;
            ready_q    <= 1'b1;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quot_q     <= quot_d;
            divisor_q  <= divisor_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            sel_rem_q  <= sel_rem_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
            valid_q    <= valid_d;
        end
    end

    assign ready_o  = ready_q;
    assign valid_o  = valid_q;
    assign result_o = result_q;

endmodule
